// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way set-associative data cache.
package dcache_pkg;

    localparam int SETS     = 8;
    localparam int WAYS     = 2;
    localparam int BLKWORDS = 2;
    localparam int DTAG_W   = 26;
    localparam int DIDX_W   = 3;

    typedef logic [31:0] word_t;

    // Field view of a byte address as the cache sees it.
    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } dcachef_t;

    // One cache frame: status bits, tag and the two-word block.
    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [DTAG_W-1:0]          tag;
        word_t [BLKWORDS-1:0]       data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FLUSH,
        FWB0,
        FWB1,
        HALTED
    } dcache_state_t;

endpackage

// File: rtl/dcache.sv
// 2-way set-associative, write-back, write-allocate data cache with
// LRU replacement, 2-word block fills and a halt-triggered dirty flush.
module dcache
    import dcache_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  halt,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output logic  dhit,
    output word_t dmemload,
    output logic  flushed,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  logic  dwait,
    input  word_t dload
);

    dcache_frame_t r_frame [WAYS][SETS];
    logic [SETS-1:0] r_lru;
    dcache_state_t   r_state;
    logic            r_victim;
    logic [3:0]      r_flushCnt;
    logic            r_flushed;

    dcachef_t          w_req;
    logic [DIDX_W-1:0] w_idx;
    logic              w_reqAny;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hitWay;
    logic              w_victim;
    logic              w_fWay;
    logic [DIDX_W-1:0] w_fIdx;
    logic              w_unused;

    assign w_req    = dcachef_t'(dmemaddr);
    assign w_idx    = w_req.idx;
    assign w_unused = ^w_req.bytoff;
    assign w_reqAny = dmemREN | dmemWEN;

    assign w_hit0   = r_frame[0][w_idx].valid && (r_frame[0][w_idx].tag == w_req.tag);
    assign w_hit1   = r_frame[1][w_idx].valid && (r_frame[1][w_idx].tag == w_req.tag);
    // Halt outranks any request, so a pending halt suppresses the hit.
    assign w_hit    = (r_state == IDLE) && !halt && w_reqAny && (w_hit0 || w_hit1);
    assign w_hitWay = !w_hit0;

    // Prefer an empty way (way0 first); otherwise evict the LRU way.
    assign w_victim = !r_frame[0][w_idx].valid ? 1'b0 :
                      !r_frame[1][w_idx].valid ? 1'b1 : r_lru[w_idx];

    assign w_fWay   = r_flushCnt[3];
    assign w_fIdx   = r_flushCnt[2:0];

    assign dhit     = w_hit;
    assign dmemload = w_hit ? r_frame[w_hitWay][w_idx].data[w_req.blkoff] : '0;
    assign flushed  = r_flushed;

    // Memory-side request lines decoded from state and the held request/counters.
    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (r_state)
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {r_frame[r_victim][w_idx].tag, w_idx, (r_state == WB1), 2'b00};
                dstore = r_frame[r_victim][w_idx].data[r_state == WB1];
            end
            LD0, LD1: begin
                dREN  = 1'b1;
                daddr = {w_req.tag, w_idx, (r_state == LD1), 2'b00};
            end
            FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = {r_frame[w_fWay][w_fIdx].tag, w_fIdx, (r_state == FWB1), 2'b00};
                dstore = r_frame[w_fWay][w_fIdx].data[r_state == FWB1];
            end
            default: begin
                dREN = 1'b0;
            end
        endcase
    end

    // Cache controller: hit updates, miss writeback/fill sequencing and halt flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_lru      <= '0;
            r_victim   <= 1'b0;
            r_flushCnt <= '0;
            r_flushed  <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_frame[w][s] <= '0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state    <= FLUSH;
                        r_flushCnt <= '0;
                    end else if (w_hit) begin
                        r_lru[w_idx] <= ~w_hitWay;
                        if (dmemWEN) begin
                            r_frame[w_hitWay][w_idx].data[w_req.blkoff] <= dmemstore;
                            r_frame[w_hitWay][w_idx].dirty               <= 1'b1;
                        end
                    end else if (w_reqAny) begin
                        r_victim <= w_victim;
                        if (r_frame[w_victim][w_idx].valid && r_frame[w_victim][w_idx].dirty) begin
                            r_state <= WB0;
                        end else begin
                            r_state <= LD0;
                        end
                    end
                end
                WB0: begin
                    if (!dwait) r_state <= WB1;
                end
                WB1: begin
                    if (!dwait) r_state <= LD0;
                end
                LD0: begin
                    if (!dwait) begin
                        r_frame[r_victim][w_idx].data[0] <= dload;
                        r_state                          <= LD1;
                    end
                end
                LD1: begin
                    if (!dwait) begin
                        r_frame[r_victim][w_idx].data[1] <= dload;
                        r_frame[r_victim][w_idx].tag     <= w_req.tag;
                        r_frame[r_victim][w_idx].valid   <= 1'b1;
                        r_frame[r_victim][w_idx].dirty   <= 1'b0;
                        r_lru[w_idx]                     <= ~r_victim;
                        r_state                          <= IDLE;
                    end
                end
                FLUSH: begin
                    if (r_frame[w_fWay][w_fIdx].dirty) begin
                        r_state <= FWB0;
                    end else if (r_flushCnt == 4'hF) begin
                        r_state   <= HALTED;
                        r_flushed <= 1'b1;
                    end else begin
                        r_flushCnt <= r_flushCnt + 4'd1;
                    end
                end
                FWB0: begin
                    if (!dwait) r_state <= FWB1;
                end
                FWB1: begin
                    if (!dwait) begin
                        r_frame[w_fWay][w_fIdx].dirty <= 1'b0;
                        if (r_flushCnt == 4'hF) begin
                            r_state   <= HALTED;
                            r_flushed <= 1'b1;
                        end else begin
                            r_flushCnt <= r_flushCnt + 4'd1;
                            r_state    <= FLUSH;
                        end
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus pushes expected hits and memory
// transfers into queues, a negedge monitor pops and compares them.
module tb_dcache;
    import dcache_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  halt;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;
    logic  flushed;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    typedef struct {
        logic  wen;
        word_t addr;
        word_t data;
    } memExp_t;

    typedef struct {
        logic  isLoad;
        word_t data;
    } hitExp_t;

    memExp_t memQ[$];
    hitExp_t hitQ[$];

    int    checks = 0;
    int    errors = 0;
    int    waitLat = 2;
    int    lcnt;
    word_t mem [0:1023];
    bit    memWritten [0:1023];
    logic  prevHold = 1'b0;
    logic  prevREN, prevWEN;
    word_t prevAddr, prevStore;

    always #5 CLK = ~CLK;

    dcache dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .halt      (halt),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload)
    );

    // Power-on memory image: one hand-picked word, everything else tagged by address.
    function automatic word_t initWord(input word_t a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | a;
    endfunction

    function automatic word_t readMem(input word_t a);
        return memWritten[a[11:2]] ? mem[a[11:2]] : initWord(a);
    endfunction

    assign dwait = (dREN | dWEN) ? (lcnt != 0) : 1'b1;
    assign dload = memWritten[daddr[11:2]] ? mem[daddr[11:2]] : initWord(daddr);

    // Memory model: dwait stays high for waitLat cycles of each transfer.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lcnt <= waitLat;
        end else if (dREN | dWEN) begin
            if (lcnt == 0) begin
                if (dWEN) begin
                    mem[daddr[11:2]]        = dstore;
                    memWritten[daddr[11:2]] = 1'b1;
                end
                lcnt <= waitLat;
            end else begin
                lcnt <= lcnt - 1;
            end
        end else begin
            lcnt <= waitLat;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expMem(input logic wen, input word_t addr, input word_t data);
        memExp_t m;
        m.wen  = wen;
        m.addr = addr;
        m.data = data;
        memQ.push_back(m);
    endtask

    task automatic expHit(input logic isLoad, input word_t data);
        hitExp_t h;
        h.isLoad = isLoad;
        h.data   = data;
        hitQ.push_back(h);
    endtask

    // Holds a request until the cache reports dhit, then drops it after the edge.
    task automatic applyStimulus(input logic ren, input logic wen, input word_t addr, input word_t data);
        int n;
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemaddr  = addr;
        dmemstore = data;
        n = 0;
        while (n < 300) begin
            @(negedge CLK);
            if (dhit) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL access timeout: addr %h got no dhit, expected dhit within 300 cycles", addr);
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    // Monitor: pop expectations whenever the cache presents a hit or finishes a transfer.
    always @(negedge CLK) begin
        if (nRST) begin
            hitExp_t h;
            memExp_t m;
            checkOutput("dREN and dWEN together", {31'd0, dREN & dWEN}, 32'd0);
            if (prevHold) begin
                checkOutput("held request lines", {30'd0, dREN, dWEN}, {30'd0, prevREN, prevWEN});
                checkOutput("held daddr", daddr, prevAddr);
                checkOutput("held dstore", dstore, prevStore);
            end
            if (dhit) begin
                checkOutput("dhit expected", {31'd0, hitQ.size() != 0}, 32'd1);
                if (hitQ.size() != 0) begin
                    h = hitQ.pop_front();
                    if (h.isLoad) checkOutput("dmemload", dmemload, h.data);
                end
            end
            if ((dREN | dWEN) && !dwait) begin
                checkOutput("transfer expected", {31'd0, memQ.size() != 0}, 32'd1);
                if (memQ.size() != 0) begin
                    m = memQ.pop_front();
                    checkOutput("transfer is write", {31'd0, dWEN}, {31'd0, m.wen});
                    checkOutput("transfer daddr", daddr, m.addr);
                    if (m.wen) checkOutput("transfer dstore", dstore, m.data);
                end
            end
            prevHold  = (dREN | dWEN) && dwait;
            prevREN   = dREN;
            prevWEN   = dWEN;
            prevAddr  = daddr;
            prevStore = dstore;
        end else begin
            prevHold = 1'b0;
        end
    end

    initial begin
        int n;
        nRST      = 1'b0;
        halt      = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset dhit", {31'd0, dhit}, 32'd0);
        checkOutput("reset dREN", {31'd0, dREN}, 32'd0);
        checkOutput("reset dWEN", {31'd0, dWEN}, 32'd0);
        checkOutput("reset daddr", daddr, 32'd0);
        checkOutput("reset dstore", dstore, 32'd0);
        checkOutput("reset flushed", {31'd0, flushed}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        $display("[TB] cold load and block-mate hit");
        expMem(1'b0, 32'h100, 32'h0);
        expMem(1'b0, 32'h104, 32'h0);
        expHit(1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        expHit(1'b1, 32'hC0DE_0104);
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0);

        $display("[TB] store hit then load back");
        expHit(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h1234_5678);
        expHit(1'b1, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);

        $display("[TB] conflict eviction in set 0");
        nRST = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST    = 1'b1;
        waitLat = 1;
        expMem(1'b0, 32'h000, 32'h0);
        expMem(1'b0, 32'h004, 32'h0);
        expHit(1'b1, 32'hC0DE_0000);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);
        expHit(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h000, 32'h1111_0000);
        expMem(1'b0, 32'h040, 32'h0);
        expMem(1'b0, 32'h044, 32'h0);
        expHit(1'b1, 32'hC0DE_0040);
        applyStimulus(1'b1, 1'b0, 32'h040, 32'h0);
        expHit(1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h044, 32'h2222_0044);
        expHit(1'b1, 32'h1111_0000);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);
        expMem(1'b1, 32'h040, 32'hC0DE_0040);
        expMem(1'b1, 32'h044, 32'h2222_0044);
        expMem(1'b0, 32'h080, 32'h0);
        expMem(1'b0, 32'h084, 32'h0);
        expHit(1'b1, 32'hC0DE_0080);
        applyStimulus(1'b1, 1'b0, 32'h080, 32'h0);
        expHit(1'b1, 32'h1111_0000);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);
        checkOutput("memory after eviction", readMem(32'h044), 32'h2222_0044);

        $display("[TB] long dwait during fill");
        waitLat = 10;
        expMem(1'b0, 32'h108, 32'h0);
        expMem(1'b0, 32'h10C, 32'h0);
        expHit(1'b1, 32'hC0DE_010C);
        applyStimulus(1'b1, 1'b0, 32'h10C, 32'h0);
        waitLat = 1;

        $display("[TB] halt flush of three dirty frames");
        expHit(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h108, 32'hE0E0_E0E0);
        expHit(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h084, 32'hE1E1_E1E1);
        expMem(1'b1, 32'h000, 32'h1111_0000);
        expMem(1'b1, 32'h004, 32'hC0DE_0004);
        expMem(1'b1, 32'h108, 32'hE0E0_E0E0);
        expMem(1'b1, 32'h10C, 32'hC0DE_010C);
        expMem(1'b1, 32'h080, 32'hC0DE_0080);
        expMem(1'b1, 32'h084, 32'hE1E1_E1E1);
        halt = 1'b1;
        n = 0;
        while (n < 300 && !flushed) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        checkOutput("flushed after flush", {31'd0, flushed}, 32'd1);
        checkOutput("flush transfers left", memQ.size(), 32'd0);
        checkOutput("flushed memory 0x108", readMem(32'h108), 32'hE0E0_E0E0);
        checkOutput("flushed memory 0x084", readMem(32'h084), 32'hE1E1_E1E1);

        $display("[TB] reset during writeback");
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        halt = 1'b0;
        #1;
        checkOutput("reset clears flushed", {31'd0, flushed}, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        expMem(1'b0, 32'h000, 32'h0);
        expMem(1'b0, 32'h004, 32'h0);
        expHit(1'b1, 32'h1111_0000);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);
        expHit(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h000, 32'hF0F0_F0F0);
        expMem(1'b0, 32'h040, 32'h0);
        expMem(1'b0, 32'h044, 32'h0);
        expHit(1'b1, 32'hC0DE_0040);
        applyStimulus(1'b1, 1'b0, 32'h040, 32'h0);
        waitLat = 5;
        expMem(1'b1, 32'h000, 32'hF0F0_F0F0);
        dmemREN  = 1'b1;
        dmemaddr = 32'h080;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (dWEN && daddr == 32'h004) break;
            n++;
        end
        checkOutput("reached WB1", {31'd0, n < 100}, 32'd1);
        #1;
        nRST    = 1'b0;
        dmemREN = 1'b0;
        #1;
        checkOutput("mid-reset dREN", {31'd0, dREN}, 32'd0);
        checkOutput("mid-reset dWEN", {31'd0, dWEN}, 32'd0);
        checkOutput("mid-reset daddr", daddr, 32'd0);
        checkOutput("mid-reset dstore", dstore, 32'd0);
        checkOutput("mid-reset dhit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        waitLat = 1;
        nRST    = 1'b1;
        checkOutput("completed WB0 kept", readMem(32'h000), 32'hF0F0_F0F0);
        checkOutput("abandoned WB1 not written", readMem(32'h004), 32'hC0DE_0004);
        expMem(1'b0, 32'h000, 32'h0);
        expMem(1'b0, 32'h004, 32'h0);
        expHit(1'b1, 32'hF0F0_F0F0);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);

        repeat (3) @(negedge CLK);
        checkOutput("hit queue drained", hitQ.size(), 32'd0);
        checkOutput("transfer queue drained", memQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
